// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {HDR, DATA, CHK, DONE, ERR} state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

   // Header byte to word count: 0 means a full memory, oversize counts saturate.
   function automatic int clamp_count(input logic [7:0] n, input int depth);
      int n_int;
      n_int = int'({24'd0, n});
      if (n_int == 0 || n_int > depth)
         return depth;
      return n_int;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream channel into the loader. A byte transfers on a rising edge where
// in_valid && in_ready; in_ready depends only on loader state, never on in_valid.
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream, first byte into [31:24].
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [BIDX_W-1:0] idx_q;
   logic [23:0]       shift_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (clr) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (byte_en) begin
         shift_q <= {shift_q[15:0], byte_in};
         idx_q   <= (idx_q == BIDX_W'(BYTES_PER_WORD - 1)) ? '0 : idx_q + BIDX_W'(1);
      end
   end

   // The completed word is presented combinationally on the edge taking the last byte.
   assign word       = {shift_q, byte_in};
   assign word_valid = byte_en && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header, N big-endian words, optional XOR
// check byte (IMEM_LOADER_CHECKSUM_EN), then releases the processor from reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   imem_loader_if.slave      stream,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_wa,
   output logic [31:0]       imem_wd,
   output logic              cpu_reset,
   output logic              done,
   output logic              err,
   output state_t            dbg_state
);

   localparam int CNT_W = ADDR_W + 1;

   state_t           state_q, state_d;
   logic             ready;
   logic             accept, hdr_take, data_take, restart_take;
   logic [CNT_W-1:0] wcnt_q, nwords_q;
   logic             last_word;
   logic [31:0]      word;
   logic             word_valid;

   assign accept       = stream.in_valid && ready;
   assign hdr_take     = accept && (state_q == HDR);
   assign data_take    = accept && (state_q == DATA);
   assign restart_take = restart && (state_q == DONE || state_q == ERR);
   assign last_word    = (wcnt_q + CNT_W'(1)) == nwords_q;
   assign stream.in_ready = ready;
   assign dbg_state    = state_q;

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (restart_take),
      .byte_en    (data_take),
      .byte_in    (stream.in_data),
      .word       (word),
      .word_valid (word_valid)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;
   logic       chk_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         chk_q <= '0;
      else if (hdr_take || restart_take)
         chk_q <= '0;
      else if (data_take)
         chk_q <= chk_q ^ stream.in_data;
   end

   assign chk_ok = (stream.in_data == chk_q);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= HDR;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR:  if (hdr_take) state_d = DATA;
         DATA: begin
            if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:  if (accept) state_d = chk_ok ? DONE : ERR;
         ERR:  if (restart_take) state_d = HDR;
`endif
         DONE: if (restart_take) state_d = HDR;
         default: state_d = HDR;
      endcase
   end

   // The processor leaves reset only once the final write pulse has retired.
   always_comb begin
      ready     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      cpu_reset = 1'b1;
      case (state_q)
         HDR, DATA: ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:  ready = 1'b1;
         ERR:  err   = 1'b1;
`endif
         DONE: begin
            done      = 1'b1;
            cpu_reset = imem_we;
         end
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we  <= 1'b0;
         imem_wa  <= '0;
         imem_wd  <= '0;
         wcnt_q   <= '0;
         nwords_q <= '0;
      end else begin
         imem_we <= word_valid;
         if (word_valid) begin
            imem_wa <= wcnt_q[ADDR_W-1:0];
            imem_wd <= word;
            wcnt_q  <= wcnt_q + CNT_W'(1);
         end
         if (hdr_take) begin
            nwords_q <= CNT_W'(clamp_count(stream.in_data, DEPTH));
            wcnt_q   <= '0;
         end
         if (restart_take) begin
            nwords_q <= '0;
            wcnt_q   <= '0;
         end
      end
   end

endmodule
